// File: rtl/decode_exec_unit_if.sv
// Decode/execute bus: instruction and register operands in, datapath
// controls and ALU result out.
interface decode_exec_unit_if #(
  parameter int unsigned WORD_WIDTH = 32
);
  logic [31:0]           instr;
  logic [WORD_WIDTH-1:0] rs_data;
  logic [WORD_WIDTH-1:0] rt_data;
  logic [1:0]            reg_dst;
  logic                  branch;
  logic [1:0]            jump;
  logic                  mem_read;
  logic                  mem_write;
  logic [1:0]            mem_to_reg;
  logic                  reg_write;
  logic [WORD_WIDTH-1:0] alu_result;
  logic                  zero;

  // Producer of the instruction/operands, consumer of the controls
  modport master (
    output instr, rs_data, rt_data,
    input  reg_dst, branch, jump, mem_read, mem_write, mem_to_reg,
           reg_write, alu_result, zero
  );

  // The decode/execute unit itself
  modport slave (
    input  instr, rs_data, rt_data,
    output reg_dst, branch, jump, mem_read, mem_write, mem_to_reg,
           reg_write, alu_result, zero
  );
endinterface

// File: rtl/decode_exec_unit.sv
// Main control, ALU-function decode and 32-bit ALU for the single-cycle
// MIPS core. Everything is computed combinationally and captured in one
// output register stage.
module decode_exec_unit #(
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  decode_exec_unit_if.slave bus
);

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_NOR  = 5'd5,
    ALU_SLT  = 5'd6,
    ALU_SLTU = 5'd7,
    ALU_SLL  = 5'd8,
    ALU_SRL  = 5'd9,
    ALU_SRA  = 5'd10,
    ALU_LUI  = 5'd11
  } alu_op_t;

  typedef enum logic [2:0] {
    AOP_ADD  = 3'd0,
    AOP_SUB  = 3'd1,
    AOP_FUNC = 3'd2,
    AOP_EXT  = 3'd3
  } alu_ctl_t;

  logic [5:0]  opcode;
  logic [5:0]  func;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic        unused_fields;

  assign opcode        = bus.instr[31:26];
  assign func          = bus.instr[5:0];
  assign shamt         = bus.instr[10:6];
  assign imm           = bus.instr[15:0];
  // Register numbers are routed to the register file by the datapath.
  assign unused_fields = ^bus.instr[25:11];

  // Main-control decode results
  logic [1:0] c_reg_dst;
  logic       c_branch;
  logic [1:0] c_jump;
  logic       c_mem_read;
  logic       c_mem_write;
  logic [1:0] c_mem_to_reg;
  logic       c_reg_write;
  alu_ctl_t   c_alu_ctl;
  alu_op_t    c_ext_op;
  logic       c_zero_ext;
  logic       c_use_rt;

  // Opcode decode: datapath controls and ALU control class
  always_comb begin
    c_reg_dst    = 2'd0;
    c_branch     = 1'b0;
    c_jump       = 2'd0;
    c_mem_read   = 1'b0;
    c_mem_write  = 1'b0;
    c_mem_to_reg = 2'd0;
    c_reg_write  = 1'b0;
    c_alu_ctl    = AOP_ADD;
    c_ext_op     = ALU_ADD;
    c_zero_ext   = 1'b0;
    c_use_rt     = 1'b0;
    unique case (opcode)
      6'h00: begin
        c_reg_dst = 2'd1;
        c_use_rt  = 1'b1;
        c_alu_ctl = AOP_FUNC;
        // jr and unknown funcs suppress the write
        case (func)
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07:
            c_reg_write = 1'b1;
          6'h08:   c_jump = 2'd2;
          default: c_reg_write = 1'b0;
        endcase
      end
      6'h08, 6'h09: c_reg_write = 1'b1;
      6'h0A: begin c_reg_write = 1'b1; c_alu_ctl = AOP_EXT; c_ext_op = ALU_SLT;  end
      6'h0B: begin c_reg_write = 1'b1; c_alu_ctl = AOP_EXT; c_ext_op = ALU_SLTU; end
      6'h0C: begin c_reg_write = 1'b1; c_alu_ctl = AOP_EXT; c_ext_op = ALU_AND; c_zero_ext = 1'b1; end
      6'h0D: begin c_reg_write = 1'b1; c_alu_ctl = AOP_EXT; c_ext_op = ALU_OR;  c_zero_ext = 1'b1; end
      6'h0E: begin c_reg_write = 1'b1; c_alu_ctl = AOP_EXT; c_ext_op = ALU_XOR; c_zero_ext = 1'b1; end
      6'h0F: begin c_reg_write = 1'b1; c_alu_ctl = AOP_EXT; c_ext_op = ALU_LUI; end
      6'h23: begin
        c_reg_write  = 1'b1;
        c_mem_read   = 1'b1;
        c_mem_to_reg = 2'd1;
      end
      6'h2B: c_mem_write = 1'b1;
      6'h04: begin
        c_branch  = 1'b1;
        c_use_rt  = 1'b1;
        c_alu_ctl = AOP_SUB;
      end
      6'h02: c_jump = 2'd1;
      6'h03: begin
        c_jump       = 2'd1;
        c_reg_dst    = 2'd2;
        c_mem_to_reg = 2'd2;
        c_reg_write  = 1'b1;
      end
      default: ;
    endcase
  end

  alu_op_t alu_op;
  logic    var_shift;

  // ALU operation select, including R-type func decode
  always_comb begin
    alu_op    = ALU_ADD;
    var_shift = 1'b0;
    case (c_alu_ctl)
      AOP_SUB: alu_op = ALU_SUB;
      AOP_EXT: alu_op = c_ext_op;
      AOP_FUNC: begin
        case (func)
          6'h22, 6'h23: alu_op = ALU_SUB;
          6'h24:        alu_op = ALU_AND;
          6'h25:        alu_op = ALU_OR;
          6'h26:        alu_op = ALU_XOR;
          6'h27:        alu_op = ALU_NOR;
          6'h2A:        alu_op = ALU_SLT;
          6'h2B:        alu_op = ALU_SLTU;
          6'h00:        alu_op = ALU_SLL;
          6'h02:        alu_op = ALU_SRL;
          6'h03:        alu_op = ALU_SRA;
          6'h04: begin alu_op = ALU_SLL; var_shift = 1'b1; end
          6'h06: begin alu_op = ALU_SRL; var_shift = 1'b1; end
          6'h07: begin alu_op = ALU_SRA; var_shift = 1'b1; end
          default:      alu_op = ALU_ADD;
        endcase
      end
      default: alu_op = ALU_ADD;
    endcase
  end

  logic [WORD_WIDTH-1:0] ext_imm;
  logic [WORD_WIDTH-1:0] op_a;
  logic [WORD_WIDTH-1:0] op_b;
  logic [4:0]            sh;
  logic [WORD_WIDTH-1:0] result;

  assign ext_imm = c_zero_ext ? {{(WORD_WIDTH-16){1'b0}}, imm}
                              : {{(WORD_WIDTH-16){imm[15]}}, imm};
  assign op_a    = bus.rs_data;
  assign op_b    = c_use_rt ? bus.rt_data : ext_imm;
  assign sh      = var_shift ? bus.rs_data[4:0] : shamt;

  // ALU datapath; arithmetic wraps, no overflow detection
  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD:  result = op_a + op_b;
      ALU_SUB:  result = op_a - op_b;
      ALU_AND:  result = op_a & op_b;
      ALU_OR:   result = op_a | op_b;
      ALU_XOR:  result = op_a ^ op_b;
      ALU_NOR:  result = ~(op_a | op_b);
      ALU_SLT:  result = {{(WORD_WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: result = {{(WORD_WIDTH-1){1'b0}}, op_a < op_b};
      ALU_SLL:  result = op_b << sh;
      ALU_SRL:  result = op_b >> sh;
      ALU_SRA:  result = $signed(op_b) >>> sh;
      ALU_LUI:  result = {op_b[15:0], 16'h0000};
      default:  result = op_a + op_b;
    endcase
  end

  // Output register stage, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.reg_dst    <= '0;
      bus.branch     <= 1'b0;
      bus.jump       <= '0;
      bus.mem_read   <= 1'b0;
      bus.mem_write  <= 1'b0;
      bus.mem_to_reg <= '0;
      bus.reg_write  <= 1'b0;
      bus.alu_result <= '0;
      bus.zero       <= 1'b0;
    end else begin
      bus.reg_dst    <= c_reg_dst;
      bus.branch     <= c_branch;
      bus.jump       <= c_jump;
      bus.mem_read   <= c_mem_read;
      bus.mem_write  <= c_mem_write;
      bus.mem_to_reg <= c_mem_to_reg;
      bus.reg_write  <= c_reg_write;
      bus.alu_result <= result;
      bus.zero       <= (result == '0);
    end
  end

endmodule

// File: tb/tb_decode_exec_unit.sv
// Directed bench for decode_exec_unit with hand-computed expectations.
module tb_decode_exec_unit;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  decode_exec_unit_if #(.WORD_WIDTH(32)) bus ();

  decode_exec_unit #(.WORD_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [5:0] func, input logic [4:0] shamt);
    return {6'h00, 5'd2, 5'd3, 5'd4, shamt, func};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd2, 5'd3, imm};
  endfunction

  // {reg_dst, branch, jump, mem_read, mem_write, mem_to_reg, reg_write}
  function automatic logic [9:0] ctl(input logic [1:0] rd, input logic br,
                                     input logic [1:0] j, input logic mr,
                                     input logic mw, input logic [1:0] m2r,
                                     input logic rw);
    return {rd, br, j, mr, mw, m2r, rw};
  endfunction

  logic [9:0] ctl_obs;
  assign ctl_obs = {bus.reg_dst, bus.branch, bus.jump, bus.mem_read,
                    bus.mem_write, bus.mem_to_reg, bus.reg_write};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    bus.instr   = i;
    bus.rs_data = a;
    bus.rt_data = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    passed      = 0;
    total       = 0;
    rst         = 1'b1;
    bus.instr   = 32'h00432020;
    bus.rs_data = 32'd5;
    bus.rt_data = 32'd7;
    #3;
    chk("reset_alu", bus.alu_result, 32'h0);
    chk("reset_ctl", {22'h0, ctl_obs}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    step(32'h00432020, 32'd5, 32'd7);
    chk("add_alu",  bus.alu_result, 32'd12);
    chk("add_zero", {31'h0, bus.zero}, 32'd0);
    chk("add_ctl",  {22'h0, ctl_obs}, {22'h0, ctl(2'd1, 0, 2'd0, 0, 0, 2'd0, 1)});

    // Asynchronous reset mid-cycle, away from any edge
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_alu", bus.alu_result, 32'h0);
    chk("async_rst_ctl", {22'h0, ctl_obs}, 32'h0);
    @(posedge clk);
    #1;
    chk("rst_held_alu", bus.alu_result, 32'h0);
    rst = 1'b0;
    step(32'h00432020, 32'd5, 32'd7);
    chk("post_rst_alu", bus.alu_result, 32'd12);
    chk("post_rst_ctl", {22'h0, ctl_obs}, {22'h0, ctl(2'd1, 0, 2'd0, 0, 0, 2'd0, 1)});

    step(rtype(6'h22, 5'd0), 32'h80000000, 32'd1);
    chk("sub_wrap", bus.alu_result, 32'h7FFFFFFF);
    step(rtype(6'h2A, 5'd0), 32'hFFFFFFFF, 32'd1);
    chk("slt_signed", bus.alu_result, 32'd1);
    step(rtype(6'h2B, 5'd0), 32'hFFFFFFFF, 32'd1);
    chk("sltu_unsigned", bus.alu_result, 32'd0);
    chk("sltu_zero", {31'h0, bus.zero}, 32'd1);
    step(rtype(6'h27, 5'd0), 32'h0F0F0000, 32'h000000F0);
    chk("nor", bus.alu_result, 32'hF0F0FF0F);
    step(rtype(6'h03, 5'd4), 32'h0, 32'hF0000000);
    chk("sra_shamt", bus.alu_result, 32'hFF000000);
    step(rtype(6'h02, 5'd4), 32'h0, 32'hF0000000);
    chk("srl_shamt", bus.alu_result, 32'h0F000000);
    step(rtype(6'h04, 5'd0), 32'h00000024, 32'd1);
    chk("sllv_5bit", bus.alu_result, 32'h00000010);
    step(rtype(6'h07, 5'd0), 32'd8, 32'h80000000);
    chk("srav", bus.alu_result, 32'hFF800000);
    step(rtype(6'h08, 5'd0), 32'h400, 32'd0);
    chk("jr_ctl", {22'h0, ctl_obs}, {22'h0, ctl(2'd1, 0, 2'd2, 0, 0, 2'd0, 0)});
    step(rtype(6'h3F, 5'd0), 32'd3, 32'd4);
    chk("bad_func_ctl", {22'h0, ctl_obs}, {22'h0, ctl(2'd1, 0, 2'd0, 0, 0, 2'd0, 0)});
    chk("bad_func_add", bus.alu_result, 32'd7);

    step(itype(6'h0D, 16'h8000), 32'h0, 32'h0);
    chk("ori_zext", bus.alu_result, 32'h00008000);
    chk("ori_ctl", {22'h0, ctl_obs}, {22'h0, ctl(2'd0, 0, 2'd0, 0, 0, 2'd0, 1)});
    step(itype(6'h0C, 16'hFFFF), 32'hFFFF1234, 32'h0);
    chk("andi_zext", bus.alu_result, 32'h00001234);
    step(itype(6'h08, 16'hFFFF), 32'd1, 32'h0);
    chk("addi_sext", bus.alu_result, 32'h0);
    chk("addi_zero", {31'h0, bus.zero}, 32'd1);
    step(itype(6'h0B, 16'hFFFF), 32'd5, 32'h0);
    chk("sltiu_sext", bus.alu_result, 32'd1);
    step(itype(6'h0A, 16'hFFFF), 32'd5, 32'h0);
    chk("slti", bus.alu_result, 32'd0);

    step(itype(6'h23, 16'h0004), 32'h100, 32'h0);
    chk("lw_addr", bus.alu_result, 32'h104);
    chk("lw_ctl", {22'h0, ctl_obs}, {22'h0, ctl(2'd0, 0, 2'd0, 1, 0, 2'd1, 1)});
    step(itype(6'h2B, 16'hFFF8), 32'h100, 32'hDEAD);
    chk("sw_addr", bus.alu_result, 32'hF8);
    chk("sw_ctl", {22'h0, ctl_obs}, {22'h0, ctl(2'd0, 0, 2'd0, 0, 1, 2'd0, 0)});
    step(itype(6'h04, 16'h0010), 32'd9, 32'd9);
    chk("beq_ctl", {22'h0, ctl_obs}, {22'h0, ctl(2'd0, 1, 2'd0, 0, 0, 2'd0, 0)});
    chk("beq_zero", {31'h0, bus.zero}, 32'd1);
    step(itype(6'h04, 16'h0010), 32'd9, 32'd8);
    chk("beq_ne_zero", {31'h0, bus.zero}, 32'd0);
    step({6'h03, 26'h0000040}, 32'h0, 32'h0);
    chk("jal_ctl", {22'h0, ctl_obs}, {22'h0, ctl(2'd2, 0, 2'd1, 0, 0, 2'd2, 1)});
    step({6'h02, 26'h0000040}, 32'h0, 32'h0);
    chk("j_ctl", {22'h0, ctl_obs}, {22'h0, ctl(2'd0, 0, 2'd1, 0, 0, 2'd0, 0)});
    step(itype(6'h0F, 16'h1234), 32'hFFFFFFFF, 32'h0);
    chk("lui", bus.alu_result, 32'h12340000);
    step(itype(6'h3F, 16'h0002), 32'd5, 32'h0);
    chk("undef_ctl", {22'h0, ctl_obs}, 32'h0);
    chk("undef_add", bus.alu_result, 32'd7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/decode_exec_unit.md
Name: decode_exec_unit

Overview:
- Combined instruction decoder (main control), ALU-function decoder and 32-bit ALU for the single-cycle MIPS core.
- Takes the fetched instruction word plus both register-file read operands.
- Produces datapath control signals and the ALU result/zero flag through one output register stage.
- Sits between RegFile read and DM/write-back muxing.

Parameters:
- WORD_WIDTH, 32, datapath width. The design is only required to support 32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- instr  input  32  instruction: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], func[5:0], imm[15:0]
- rs_data  input  32  register operand A (rs)
- rt_data  input  32  register operand B (rt)
- reg_dst  output  2  write-register select: 0=rt, 1=rd, 2=constant 31
- branch  output  1  beq instruction
- jump  output  2  0=none, 1=j/jal (target from instr[25:0]), 2=jr
- mem_read  output  1  DM read enable
- mem_write  output  1  DM write enable
- mem_to_reg  output  2  write-back select: 0=ALU, 1=memory, 2=PC+4
- reg_write  output  1  register-file write enable
- alu_result  output  32  ALU output
- zero  output  1  alu_result==0

Behaviour:
- All outputs are registered: values are decoded/computed combinationally from the current inputs and captured on the rising clk edge. Latency is 1 cycle.
- rst high: all outputs go to 0 immediately, independent of clk, and are held at 0 while rst is asserted. The first capture occurs on the first clk edge after rst is released.
- Immediate extension: sign-extend by default; zero-extend for andi, ori, xori.
- ALU operand B: rt_data for R-type and beq; the extended immediate otherwise.
- ALU operations (5-bit internal code):
  - ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, SLTU=7, SLL=8, SRL=9, SRA=10, LUI=11.
- Internal ALUOp (3 bits) from main control: 0=ADD, 1=SUB, 2=decode func, 3=use ext op supplied by main control.
- R-type (opcode 0x00), all with reg_dst=1, reg_write=1, mem_to_reg=0. Func decode:
  - add/addu 0x20/0x21 -> ADD
  - sub/subu 0x22/0x23 -> SUB
  - and 0x24, or 0x25, xor 0x26, nor 0x27
  - slt 0x2A (signed), sltu 0x2B (unsigned); result is 1 or 0
  - sll 0x00, srl 0x02, sra 0x03: shift B by shamt
  - sllv 0x04, srlv 0x06, srav 0x07: shift B by rs_data[4:0]
  - jr 0x08: jump=2, reg_write=0
  - any other func: reg_write=0, ALU performs ADD
- I/J-type opcodes:
  - addi/addiu 0x08/0x09: ADD, reg_dst=0, reg_write=1
  - slti 0x0A: SLT; sltiu 0x0B: SLTU (compares against the sign-extended immediate, unsigned); both reg_dst=0, reg_write=1
  - andi 0x0C, ori 0x0D, xori 0x0E: zero-extended immediate, reg_dst=0, reg_write=1
  - lui 0x0F: result = {imm,16'b0}, reg_dst=0, reg_write=1
  - lw 0x23: ADD, mem_read=1, mem_to_reg=1, reg_dst=0, reg_write=1
  - sw 0x2B: ADD, mem_write=1, reg_write=0
  - beq 0x04: SUB, branch=1, reg_write=0
  - j 0x02: jump=1, no writes
  - jal 0x03: jump=1, reg_dst=2, mem_to_reg=2, reg_write=1
  - any other opcode: all controls 0, ALU performs ADD
- Arithmetic wraps modulo 2^32. There is no overflow trap or flag; add and addu behave identically.
- Shifts use only 5 bits of shift amount. SRA replicates bit 31.
- Register fields (rs/rt/rd) are not output; the datapath takes them from the instruction.

Test Plan:
- Assert rst mid-operation with instr=add -> all outputs 0 immediately, before any clk edge. Release rst, clock once -> outputs reflect the current instr.
- add (0x00432020), rs_data=5, rt_data=7 -> after 1 edge: alu_result=12, zero=0, reg_dst=1, reg_write=1, mem_to_reg=0.
- sub with rs_data=0x80000000, rt_data=1 -> alu_result=0x7FFFFFFF (wraps, no trap). slt with rs_data=0xFFFFFFFF, rt_data=1 -> 1. sltu with the same operands -> 0.
- ori with imm=0x8000, rs_data=0 -> alu_result=0x00008000 (zero-extended). addi with imm=0xFFFF, rs_data=1 -> alu_result=0, zero=1.
- lw with imm=4, rs_data=0x100 -> alu_result=0x104, mem_read=1, mem_to_reg=1, reg_dst=0. sw -> mem_write=1, reg_write=0.
- beq with rs_data=rt_data=9 -> branch=1, zero=1.
- jal -> jump=1, reg_dst=2, mem_to_reg=2, reg_write=1.
- sra with shamt=4, rt_data=0xF0000000 -> alu_result=0xFF000000.
- lui with imm=0x1234 -> alu_result=0x12340000.
- Undefined opcode 0x3F -> all control outputs 0.
